ixc_osftbc_pipe: RTL

IXC_OSFTBC_PIPE -- requirements
Module: ixc_osftbc_pipe

---
 rtl/ixc_osftbc_pkg.sv | 17 +
 rtl/ixc_osftbc_pipe_if.sv | 30 +++
 rtl/ixc_osftbc_chan.sv | 62 ++++++
 rtl/ixc_osftbc_pipe.sv | 56 +++++
 4 files changed

// File: rtl/ixc_osftbc_pkg.sv
// Shared constants and helpers for the osfTbc register pipeline.
// Provides the parameter limits, the default geometry and the fill-counter sizing function.
package ixc_osftbc_pkg;

  localparam int DEPTH_MAX = 8;
  localparam int CH_MAX    = 32;

  localparam int CH_DEF    = 4;
  localparam int DEPTH_DEF = 2;
  localparam int CNT_W_DEF = 8;

  // Fill counter must represent 0..DEPTH inclusive.
  function automatic int fillWidth(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/ixc_osftbc_pipe_if.sv
// Bundle of the per-channel data, control and status signals of the osfTbc pipeline.
// The master drives data and control; the slave is the pipeline itself.
interface ixc_osftbc_pipe_if
  import ixc_osftbc_pkg::*;
#(
  parameter int CH    = CH_DEF,
  parameter int CNT_W = CNT_W_DEF
) ();

  logic [CH-1:0]       osfTbcI;
  logic                en;
  logic [CH-1:0]       hold;
  logic                flush;
  logic                cnt_clr;
  logic [CH-1:0]       osfTbcO;
  logic [CH-1:0]       osfTbcRise;
  logic [CH*CNT_W-1:0] rise_cnt;
  logic                valid;

  modport master (
    output osfTbcI, en, hold, flush, cnt_clr,
    input  osfTbcO, osfTbcRise, rise_cnt, valid
  );

  modport slave (
    input  osfTbcI, en, hold, flush, cnt_clr,
    output osfTbcO, osfTbcRise, rise_cnt, valid
  );

endinterface

// File: rtl/ixc_osftbc_chan.sv
// One osfTbc channel: a DEPTH-stage shift chain, a registered rise detector on the
// last stage and a saturating rise counter.
module ixc_osftbc_chan
  import ixc_osftbc_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             advance,
  input  logic             flush,
  input  logic             cntClr,
  output logic             dout,
  output logic             rise,
  output logic [CNT_W-1:0] riseCnt
);

  logic [DEPTH-1:0] stages;
  logic [DEPTH-1:0] shifted;

  // Next chain contents on an advancing edge; handles DEPTH=1 without a negative index.
  always_comb begin
    shifted    = '0;
    shifted[0] = din;
    for (int k = 1; k < DEPTH; k++) begin
      shifted[k] = stages[k-1];
    end
  end

  // Rise is decided from the value the last stage is about to take, so the pulse
  // lines up with the first cycle dout shows 1; flush clears to 0 and never pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stages <= '0;
      rise   <= 1'b0;
    end else if (flush) begin
      stages <= '0;
      rise   <= 1'b0;
    end else if (advance) begin
      stages <= shifted;
      rise   <= shifted[DEPTH-1] & ~stages[DEPTH-1];
    end else begin
      rise   <= 1'b0;
    end
  end

  // Clear wins over a coincident rise; the counter sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      riseCnt <= '0;
    end else if (cntClr) begin
      riseCnt <= '0;
    end else if (rise && (riseCnt != '1)) begin
      riseCnt <= riseCnt + CNT_W'(1);
    end
  end

  assign dout = stages[DEPTH-1];

endmodule

// File: rtl/ixc_osftbc_pipe.sv
// Multi-channel osfTbc register pipeline: CH independent channels plus a shared
// fill counter that reports when the chain holds DEPTH advanced samples.
(* always_on = "true" *)
module ixc_osftbc_pipe
  import ixc_osftbc_pkg::*;
#(
  parameter int CH    = CH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input logic               clk,
  input logic               rst_n,
  ixc_osftbc_pipe_if.slave  bus
);

  localparam int FILL_W = fillWidth(DEPTH);

  logic [FILL_W-1:0]   fillCnt;
  logic [CH-1:0]       outBits;
  logic [CH-1:0]       riseBits;
  logic [CH*CNT_W-1:0] cntBits;

  for (genvar i = 0; i < CH; i++) begin : gChan
    ixc_osftbc_chan #(
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
    ) uChan (
      .clk     (clk),
      .rst_n   (rst_n),
      .din     (bus.osfTbcI[i]),
      .advance (bus.en & ~bus.hold[i]),
      .flush   (bus.flush),
      .cntClr  (bus.cnt_clr),
      .dout    (outBits[i]),
      .rise    (riseBits[i]),
      .riseCnt (cntBits[i*CNT_W +: CNT_W])
    );
  end

  // Fill tracks global advances only; a held channel still counts as filled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fillCnt <= '0;
    end else if (bus.flush) begin
      fillCnt <= '0;
    end else if (bus.en && (fillCnt != FILL_W'(DEPTH))) begin
      fillCnt <= fillCnt + FILL_W'(1);
    end
  end

  assign bus.osfTbcO    = outBits;
  assign bus.osfTbcRise = riseBits;
  assign bus.rise_cnt   = cntBits;
  assign bus.valid      = (fillCnt == FILL_W'(DEPTH));

endmodule
